// File: rtl/i2c_sb_initiator.sv
// System-bus initiator for the hard I2C FIFO IP: turns one register write/read
// request into the TXDR/CMDR/SR/RXDR access sequence the IP expects.
module i2c_sb_initiator #(
  parameter int unsigned     SBAW     = 8,
  parameter logic [SBAW-1:0] ADR_CMDR = SBAW'(8'h09),
  parameter logic [SBAW-1:0] ADR_TXDR = SBAW'(8'h0D),
  parameter logic [SBAW-1:0] ADR_SR   = SBAW'(8'h0C),
  parameter logic [SBAW-1:0] ADR_RXDR = SBAW'(8'h0E),
  parameter int unsigned     POLL_MAX = 1023
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_rd,
  input  logic [6:0]      req_dev,
  input  logic [7:0]      req_reg,
  input  logic [7:0]      req_wdata,
  output logic            rsp_valid,
  output logic            rsp_err,
  output logic [7:0]      rsp_rdata,
  output logic            sb_stb_o,
  output logic            sb_cs_o,
  output logic            sb_we_o,
  output logic [SBAW-1:0] sb_adr_o,
  output logic [7:0]      sb_dat_o,
  input  logic [7:0]      sb_dat_i,
  input  logic            sb_ack_i
);
  localparam logic [7:0] CMD_STA_WR = 8'h94;
  localparam logic [7:0] CMD_WR     = 8'h14;
  localparam logic [7:0] CMD_STO    = 8'h44;
  localparam logic [7:0] CMD_RD_STO = 8'h6C;
  localparam int unsigned SR_TRRDY  = 2;
  localparam int unsigned SR_RARC   = 5;
  localparam int unsigned PCW       = (POLL_MAX > 1) ? $clog2(POLL_MAX) : 1;
  localparam logic [PCW-1:0] POLL_LAST = PCW'(POLL_MAX - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_WR_TX, ST_WR_CMD, ST_POLL, ST_STOP_ERR, ST_RD_RX, ST_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      step_q, step_d;
  logic [PCW-1:0]  poll_cnt_q, poll_cnt_d;
  logic            rd_q, rd_d;
  logic [6:0]      dev_q, dev_d;
  logic [7:0]      reg_q, reg_d;
  logic [7:0]      wdata_q, wdata_d;
  logic            stb_q, stb_d;
  logic            we_q, we_d;
  logic [SBAW-1:0] adr_q, adr_d;
  logic [7:0]      dat_q, dat_d;
  logic            rsp_err_q, rsp_err_d;
  logic [7:0]      rdata_q, rdata_d;

  logic [7:0]      tx_byte, cmd;
  logic            acc_en, acc_we, acc_done;
  logic [SBAW-1:0] acc_adr;
  logic [7:0]      acc_dat;

  // Steps 0..2 are the three SEND bytes; step 3 is the final STOP (write) or RD+STOP (read).
  always_comb begin
    tx_byte = {dev_q, 1'b0};
    cmd     = CMD_STA_WR;
    case (step_q)
      3'd0: begin tx_byte = {dev_q, 1'b0}; cmd = CMD_STA_WR; end
      3'd1: begin tx_byte = reg_q;         cmd = CMD_WR;     end
      3'd2: begin
        tx_byte = rd_q ? {dev_q, 1'b1} : wdata_q;
        cmd     = rd_q ? CMD_STA_WR    : CMD_WR;
      end
      default: cmd = rd_q ? CMD_RD_STO : CMD_STO;
    endcase
  end

  always_comb begin
    acc_en  = 1'b1;
    acc_we  = 1'b1;
    acc_adr = ADR_CMDR;
    acc_dat = cmd;
    case (state_q)
      ST_WR_TX:    begin acc_adr = ADR_TXDR; acc_dat = tx_byte; end
      ST_WR_CMD:   ;
      ST_POLL:     begin acc_we = 1'b0; acc_adr = ADR_SR;   acc_dat = 8'h00; end
      ST_STOP_ERR: acc_dat = CMD_STO;
      ST_RD_RX:    begin acc_we = 1'b0; acc_adr = ADR_RXDR; acc_dat = 8'h00; end
      default:     acc_en = 1'b0;
    endcase
  end

  assign acc_done = stb_q && sb_ack_i;

  // NOTE: every variable gets its hold value first, so no path through the case can infer a latch.
  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    poll_cnt_d = poll_cnt_q;
    rd_d       = rd_q;
    dev_d      = dev_q;
    reg_d      = reg_q;
    wdata_d    = wdata_q;
    stb_d      = stb_q;
    we_d       = we_q;
    adr_d      = adr_q;
    dat_d      = dat_q;
    rsp_err_d  = rsp_err_q;
    rdata_d    = rdata_q;

    // A state's access launches on its first cycle; the ack cycle drops stb, giving the idle gap.
    if (acc_en && !stb_q) begin
      stb_d = 1'b1;
      we_d  = acc_we;
      adr_d = acc_adr;
      dat_d = acc_dat;
    end
    if (acc_done) stb_d = 1'b0;

    case (state_q)
      ST_IDLE: if (req_valid) begin
        rd_d      = req_rd;
        dev_d     = req_dev;
        reg_d     = req_reg;
        wdata_d   = req_wdata;
        step_d    = 3'd0;
        rsp_err_d = 1'b0;
        rdata_d   = 8'h00;
        state_d   = ST_WR_TX;
      end
      ST_WR_TX: if (acc_done) state_d = ST_WR_CMD;
      ST_WR_CMD: if (acc_done) begin
        poll_cnt_d = '0;
        state_d    = (!rd_q && step_q == 3'd3) ? ST_DONE : ST_POLL;
      end
      ST_POLL: if (acc_done) begin
        if (sb_dat_i[SR_TRRDY]) begin
          if (step_q == 3'd3) state_d = ST_RD_RX;
          else if (sb_dat_i[SR_RARC]) state_d = ST_STOP_ERR;
          else begin
            step_d  = step_q + 3'd1;
            state_d = (step_q == 3'd2) ? ST_WR_CMD : ST_WR_TX;
          end
        end else if (poll_cnt_q == POLL_LAST) begin
          state_d = ST_STOP_ERR;
        end else begin
          poll_cnt_d = poll_cnt_q + PCW'(1);
        end
      end
      ST_STOP_ERR: if (acc_done) begin
        rsp_err_d = 1'b1;
        state_d   = ST_DONE;
      end
      ST_RD_RX: if (acc_done) begin
        rdata_d = sb_dat_i;
        state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_IDLE;
      step_q     <= 3'd0;
      poll_cnt_q <= '0;
      rd_q       <= 1'b0;
      dev_q      <= 7'h00;
      reg_q      <= 8'h00;
      wdata_q    <= 8'h00;
      stb_q      <= 1'b0;
      we_q       <= 1'b0;
      adr_q      <= '0;
      dat_q      <= 8'h00;
      rsp_err_q  <= 1'b0;
      rdata_q    <= 8'h00;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      poll_cnt_q <= poll_cnt_d;
      rd_q       <= rd_d;
      dev_q      <= dev_d;
      reg_q      <= reg_d;
      wdata_q    <= wdata_d;
      stb_q      <= stb_d;
      we_q       <= we_d;
      adr_q      <= adr_d;
      dat_q      <= dat_d;
      rsp_err_q  <= rsp_err_d;
      rdata_q    <= rdata_d;
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_DONE);
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rdata_q;
  assign sb_stb_o  = stb_q;
  assign sb_cs_o   = stb_q;
  assign sb_we_o   = we_q;
  assign sb_adr_o  = adr_q;
  assign sb_dat_o  = dat_q;

endmodule

// File: tb/tb_i2c_sb_initiator.sv
// Bench for i2c_sb_initiator: a small IP model answers bus accesses, and
// scoreboards compare bus writes and responses against hand-computed values.
module tb_i2c_sb_initiator;
  localparam int unsigned POLL_MAX = 4;
  localparam logic [7:0] A_CMDR = 8'h09, A_TXDR = 8'h0D, A_SR = 8'h0C, A_RXDR = 8'h0E;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0, req_rd = 1'b0;
  logic [6:0] req_dev = '0;
  logic [7:0] req_reg = '0, req_wdata = '0;
  logic       req_ready, rsp_valid, rsp_err;
  logic [7:0] rsp_rdata;
  logic       sb_stb, sb_cs, sb_we;
  logic [7:0] sb_adr, sb_dat_o;
  logic [7:0] sb_dat_i = '0;
  logic       sb_ack = 1'b0;

  i2c_sb_initiator #(.SBAW(8), .POLL_MAX(POLL_MAX)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_rd(req_rd),
    .req_dev(req_dev), .req_reg(req_reg), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .sb_stb_o(sb_stb), .sb_cs_o(sb_cs), .sb_we_o(sb_we), .sb_adr_o(sb_adr),
    .sb_dat_o(sb_dat_o), .sb_dat_i(sb_dat_i), .sb_ack_i(sb_ack)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  logic [15:0] exp_wr_q[$];
  logic [8:0]  exp_rsp_q[$];
  int sr_reads = 0, acc_total = 0, cmdr_total = 0, polls_byte = 0, ack_wait = 0;
  int rsp_cnt = 0, accepts = 0;
  int trrdy_after = 1, rarc_target = -1;
  logic [7:0] rxdr_val = 8'h00;
  logic trrdy, rarc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // IP model: acks each access two cycles after stb rises and returns SR/RXDR data.
  always @(negedge clk) begin
    if (!sb_stb || sb_ack) begin
      ack_wait = 0;
      sb_ack   = 1'b0;
    end else if (ack_wait < 1) begin
      ack_wait++;
    end else begin
      sb_ack = 1'b1;
      acc_total++;
      check("cs_follows_stb", {31'd0, sb_cs}, 32'd1);
      if (sb_we) begin
        if (exp_wr_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write: got adr %0h dat %0h expected none", sb_adr, sb_dat_o);
        end else begin
          check("bus_write", {16'd0, sb_adr, sb_dat_o}, {16'd0, exp_wr_q.pop_front()});
        end
        if (sb_adr == A_CMDR) begin
          cmdr_total++;
          polls_byte = 0;
        end
      end else if (sb_adr == A_SR) begin
        sr_reads++;
        polls_byte++;
        trrdy    = (trrdy_after != 0) && (polls_byte >= trrdy_after);
        rarc     = (cmdr_total == rarc_target);
        sb_dat_i = {2'b00, rarc, 2'b00, trrdy, 2'b00};
      end else if (sb_adr == A_RXDR) begin
        sb_dat_i = rxdr_val;
      end else begin
        sb_dat_i = 8'hEE;
      end
    end
  end

  // Response monitor.
  always @(negedge clk) begin
    if (rsp_valid) begin
      rsp_cnt++;
      check("ready_low_in_done", {31'd0, req_ready}, 32'd0);
      if (exp_rsp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_rsp: got err %0b rdata %0h expected none", rsp_err, rsp_rdata);
      end else begin
        logic [8:0] e;
        e = exp_rsp_q.pop_front();
        check("rsp_err", {31'd0, rsp_err}, {31'd0, e[8]});
        check("rsp_rdata", {24'd0, rsp_rdata}, {24'd0, e[7:0]});
      end
    end
  end

  always @(negedge clk) if (rst_n && req_valid && req_ready) accepts++;

  task automatic push_wr(input logic [7:0] adr, input logic [7:0] dat);
    exp_wr_q.push_back({adr, dat});
  endtask

  task automatic push_seq(input logic rd, input logic [6:0] dev, input logic [7:0] rg,
                          input logic [7:0] wd);
    push_wr(A_TXDR, {dev, 1'b0}); push_wr(A_CMDR, 8'h94);
    push_wr(A_TXDR, rg);          push_wr(A_CMDR, 8'h14);
    if (rd) begin
      push_wr(A_TXDR, {dev, 1'b1}); push_wr(A_CMDR, 8'h94); push_wr(A_CMDR, 8'h6C);
    end else begin
      push_wr(A_TXDR, wd); push_wr(A_CMDR, 8'h14); push_wr(A_CMDR, 8'h44);
    end
  endtask

  task automatic send_req(input logic rd, input logic [6:0] dev, input logic [7:0] rg,
                          input logic [7:0] wd);
    int n = 0;
    while (!req_ready && n < 1000) begin @(posedge clk); #1; n++; end
    req_rd = rd; req_dev = dev; req_reg = rg; req_wdata = wd; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int target);
    int n = 0;
    while (rsp_cnt < target && n < 3000) begin @(posedge clk); #1; n++; end
    check("rsp_count", rsp_cnt, target);
    @(posedge clk); #1;
  endtask

  int base_sr, base_acc, base_cmdr, base_acpt, n;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk); #1;
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    check("rst_stb_cs_we", {29'd0, sb_stb, sb_cs, sb_we}, 32'd0);
    check("rst_adr_dat_rdata", {8'd0, sb_adr, sb_dat_o, rsp_rdata}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Write with TRRDY on the third poll of every byte.
    trrdy_after = 3; rarc_target = -1;
    base_sr = sr_reads; base_acc = acc_total;
    push_seq(1'b0, 7'h24, 8'h10, 8'hA5);
    exp_rsp_q.push_back({1'b0, 8'h00});
    send_req(1'b0, 7'h24, 8'h10, 8'hA5);
    wait_rsp(1);
    check("wr_sr_reads", sr_reads - base_sr, 9);
    check("wr_access_count", acc_total - base_acc, 16);
    check("wr_queue_empty", exp_wr_q.size(), 0);

    // Read; TRRDY lands exactly on the POLL_MAX-th poll, which must still succeed.
    trrdy_after = 4; rxdr_val = 8'h5C;
    base_sr = sr_reads;
    push_seq(1'b1, 7'h24, 8'h01, 8'h00);
    exp_rsp_q.push_back({1'b0, 8'h5C});
    send_req(1'b1, 7'h24, 8'h01, 8'h00);
    wait_rsp(2);
    check("rd_sr_reads", sr_reads - base_sr, 16);
    check("rd_queue_empty", exp_wr_q.size(), 0);
    repeat (3) @(posedge clk); #1;
    check("rdata_hold", {24'd0, rsp_rdata}, 32'h5C);

    // RARC after the device byte: STOP immediately, no more TXDR writes.
    trrdy_after = 1; rarc_target = cmdr_total + 1;
    base_sr = sr_reads;
    push_wr(A_TXDR, 8'h48); push_wr(A_CMDR, 8'h94); push_wr(A_CMDR, 8'h44);
    exp_rsp_q.push_back({1'b1, 8'h00});
    send_req(1'b0, 7'h24, 8'h10, 8'hA5);
    wait_rsp(3);
    check("nack_sr_reads", sr_reads - base_sr, 1);
    check("nack_queue_empty", exp_wr_q.size(), 0);
    rarc_target = -1;

    // TRRDY never set: exactly POLL_MAX SR reads then STOP with error.
    trrdy_after = 0;
    base_sr = sr_reads;
    push_wr(A_TXDR, 8'h48); push_wr(A_CMDR, 8'h94); push_wr(A_CMDR, 8'h44);
    exp_rsp_q.push_back({1'b1, 8'h00});
    send_req(1'b1, 7'h24, 8'h01, 8'h00);
    wait_rsp(4);
    check("timeout_sr_reads", sr_reads - base_sr, 4);
    check("timeout_queue_empty", exp_wr_q.size(), 0);

    // Reset while polling the second byte.
    trrdy_after = 3;
    base_cmdr = cmdr_total;
    push_wr(A_TXDR, 8'h48); push_wr(A_CMDR, 8'h94); push_wr(A_TXDR, 8'h10); push_wr(A_CMDR, 8'h14);
    send_req(1'b0, 7'h24, 8'h10, 8'hA5);
    n = 0;
    while (!(cmdr_total == base_cmdr + 2 && polls_byte >= 1) && n < 500) begin
      @(posedge clk); #1; n++;
    end
    check("reached_byte2_poll", cmdr_total - base_cmdr, 2);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst_stb", {31'd0, sb_stb}, 32'd0);
    check("midrst_ready", {31'd0, req_ready}, 32'd1);
    check("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk); #1;
    check("midrst_no_rsp", rsp_cnt, 4);
    check("midrst_queue_empty", exp_wr_q.size(), 0);

    trrdy_after = 1; rxdr_val = 8'h5C;
    push_seq(1'b1, 7'h24, 8'h01, 8'h00);
    exp_rsp_q.push_back({1'b0, 8'h5C});
    send_req(1'b1, 7'h24, 8'h01, 8'h00);
    wait_rsp(5);
    check("post_rst_queue_empty", exp_wr_q.size(), 0);

    // req_valid held high across DONE: second request waits for IDLE.
    base_acpt = accepts;
    push_seq(1'b0, 7'h24, 8'h10, 8'hA5);
    push_seq(1'b0, 7'h51, 8'h22, 8'h3C);
    exp_rsp_q.push_back({1'b0, 8'h00});
    exp_rsp_q.push_back({1'b0, 8'h00});
    req_rd = 1'b0; req_dev = 7'h24; req_reg = 8'h10; req_wdata = 8'hA5; req_valid = 1'b1;
    @(posedge clk); #1;
    req_dev = 7'h51; req_reg = 8'h22; req_wdata = 8'h3C;
    n = 0;
    while (accepts < base_acpt + 2 && n < 3000) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_rsp(7);
    repeat (5) @(posedge clk); #1;
    check("held_accepts", accepts - base_acpt, 2);
    check("held_rsp_total", rsp_cnt, 7);
    check("held_queue_empty", exp_wr_q.size(), 0);
    check("rsp_queue_empty", exp_rsp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
